// File: rtl/readout_sequencer.sv
// readout_sequencer: row-by-row pixel array readout (select, convert, latch)
// streaming latched pixels row-major over valid/ready, with an end-of-frame pulse.
module readout_sequencer #(
    parameter int N_ROWS     = 2,
    parameter int N_COLS     = 2,
    parameter int DATA_W     = 8,
    parameter int SETTLE_CYC = 1,
    parameter int ADC_CYC    = 2,
    localparam int RW = N_ROWS > 1 ? $clog2(N_ROWS) : 1,
    localparam int CW = N_COLS > 1 ? $clog2(N_COLS) : 1
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Start,
    input  logic [N_COLS*DATA_W-1:0] Adc_data,
    input  logic                     Pix_ready,
    output logic [N_ROWS-1:0]        NRE,
    output logic                     ADC,
    output logic                     Busy,
    output logic                     Done,
    output logic                     Pix_valid,
    output logic [DATA_W-1:0]        Pix_data,
    output logic [RW-1:0]            Pix_row,
    output logic [CW-1:0]            Pix_col
);
    localparam int TMAX = SETTLE_CYC > ADC_CYC ? SETTLE_CYC : ADC_CYC;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {IDLE, SETTLE, CONVERT, DRAIN, DONE} state_t;

    state_t                   state, state_n;
    logic [RW-1:0]            row, row_n;
    logic [CW-1:0]            col, col_n;
    logic [TW-1:0]            tmr, tmr_n;
    logic [N_COLS*DATA_W-1:0] row_buf, buf_n;
    logic [N_ROWS-1:0]        sel;

    always_comb begin
        state_n = state;
        row_n   = row;
        col_n   = col;
        tmr_n   = tmr;
        buf_n   = row_buf;
        case (state)
            IDLE: if (Start) begin
                state_n = SETTLE;
                row_n   = '0;
                tmr_n   = '0;
            end
            SETTLE: if (tmr == TW'(SETTLE_CYC - 1)) begin
                state_n = CONVERT;
                tmr_n   = '0;
            end else tmr_n = tmr + 1'b1;
            CONVERT: if (tmr == TW'(ADC_CYC - 1)) begin
                state_n = DRAIN;
                tmr_n   = '0;
                col_n   = '0;
                buf_n   = Adc_data;
            end else tmr_n = tmr + 1'b1;
            // Pix_valid is always high in DRAIN, so ready alone marks a transfer
            DRAIN: if (Pix_ready) begin
                if (col == CW'(N_COLS - 1)) begin
                    col_n = '0;
                    if (row == RW'(N_ROWS - 1)) state_n = DONE;
                    else begin
                        state_n = SETTLE;
                        row_n   = row + 1'b1;
                    end
                end else col_n = col + 1'b1;
            end
            DONE: begin
                state_n = IDLE;
                row_n   = '0;
            end
            default: state_n = IDLE;
        endcase
        sel        = '0;
        sel[row_n] = 1'b1;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            row     <= '0;
            col     <= '0;
            tmr     <= '0;
            row_buf <= '0;
        end else begin
            state   <= state_n;
            row     <= row_n;
            col     <= col_n;
            tmr     <= tmr_n;
            row_buf <= buf_n;
        end
    end

    // Outputs are registered from the next-state view so they line up with the state
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            NRE       <= '1;
            ADC       <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Pix_valid <= 1'b0;
            Pix_data  <= '0;
            Pix_row   <= '0;
            Pix_col   <= '0;
        end else begin
            NRE       <= (state_n == SETTLE || state_n == CONVERT) ? ~sel : '1;
            ADC       <= state_n == CONVERT;
            Busy      <= state_n != IDLE;
            Done      <= state_n == DONE;
            Pix_valid <= state_n == DRAIN;
            if (state_n == DRAIN) begin
                Pix_data <= buf_n[col_n*DATA_W +: DATA_W];
                Pix_row  <= row_n;
                Pix_col  <= col_n;
            end
        end
    end
endmodule

// File: tb/tb_readout_sequencer.sv
// tb_readout_sequencer: randomized frames against a scoreboard of expected pixels
// plus frame-level timing derived from per-row cycle arithmetic.
module tb_readout_sequencer;
    localparam int NR = 2, NC = 2, DW = 8, SC = 1, AC = 2;
    localparam int RW = 1, CW = 1, AW = NC * DW;
    localparam int RC = SC + AC + NC;
    localparam int PW = RW + CW + DW;

    logic          Clk = 0, Reset = 1, Start = 0, Pix_ready = 0;
    logic [AW-1:0] Adc_data;
    logic [NR-1:0] NRE;
    logic          ADC, Busy, Done, Pix_valid;
    logic [DW-1:0] Pix_data;
    logic [RW-1:0] Pix_row;
    logic [CW-1:0] Pix_col;

    int compared = 0, mismatched = 0;
    logic [AW-1:0] rowval [NR];
    logic [AW-1:0] junk = '0;
    bit            junk_ones = 0;
    logic [PW-1:0] sb [$];

    readout_sequencer #(.N_ROWS(NR), .N_COLS(NC), .DATA_W(DW), .SETTLE_CYC(SC), .ADC_CYC(AC)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Adc_data(Adc_data), .Pix_ready(Pix_ready),
        .NRE(NRE), .ADC(ADC), .Busy(Busy), .Done(Done), .Pix_valid(Pix_valid),
        .Pix_data(Pix_data), .Pix_row(Pix_row), .Pix_col(Pix_col)
    );

    always #5 Clk = ~Clk;

    // Column ADCs report the selected row; anything else on the bus is junk
    always_comb begin
        Adc_data = junk;
        for (int r = 0; r < NR; r++) if (!NRE[r]) Adc_data = rowval[r];
    end

    always @(posedge Clk) junk <= junk_ones ? '1 : AW'($urandom);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (!Reset && Pix_valid && Pix_ready) begin
            if (sb.size() == 0) check("pixel_unexpected", 64'(Pix_data), 64'hDEAD);
            else check("pixel", 64'({Pix_row, Pix_col, Pix_data}), 64'(sb.pop_front()));
        end
    end

    // mode 0: ready always high with exact cycle checks; 1: stall cycles 4-6; 2: random ready
    task automatic run_frame(input int mode, input bit extra_start);
        int done_cyc, stalls, k, o;
        logic [NR-1:0] enre;
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                sb.push_back({RW'(r), CW'(c), rowval[r][c*DW +: DW]});
        Start = 1;
        @(posedge Clk); #1;
        done_cyc = 0;
        stalls = 0;
        for (int cyc = 1; cyc < 300 && done_cyc == 0; cyc++) begin
            Start = extra_start && (cyc == 3 || cyc == NR * RC + 1);
            Pix_ready = mode == 0 ? 1'b1 : mode == 1 ? !(cyc >= 4 && cyc <= 6) : 1'($urandom_range(0, 1));
            @(negedge Clk);
            if (Pix_valid && !Pix_ready) stalls++;
            check("invariants", 64'(($countones(~NRE) <= 1) && (!ADC || NRE != '1) &&
                  (!Pix_valid || (NRE == '1 && !ADC)) && Busy && !(Done && Pix_valid)), 64'd1);
            if (mode == 0) begin
                k = (cyc - 1) / RC;
                o = (cyc - 1) % RC;
                enre = '1;
                if (k < NR && o < SC + AC) enre[k] = 1'b0;
                check("timing", 64'({NRE, ADC, Pix_valid, Done}),
                      64'({enre, k < NR && o >= SC && o < SC + AC, k < NR && o >= SC + AC, cyc == NR * RC + 1}));
            end
            if (mode == 1 && cyc >= 4 && cyc <= 7)
                check("stall_hold", 64'({Pix_valid, NRE, ADC, Pix_data}), 64'({1'b1, {NR{1'b1}}, 1'b0, rowval[0][DW-1:0]}));
            if (Done) done_cyc = cyc;
            @(posedge Clk); #1;
        end
        Start = 0;
        check("done_cycle", 64'(done_cyc), 64'(NR * RC + 1 + stalls));
        check("busy_after_done", 64'({Busy, Done}), 64'd0);
        check("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    task automatic abort_frame();
        Start = 1;
        @(posedge Clk); #1;
        Start = 0;
        @(posedge Clk); #1;
        check("abort_in_convert", 64'({ADC, Busy}), 64'b11);
        Reset = 1;
        #1;
        check("reset_mid_frame", 64'({NRE, ADC, Busy, Done, Pix_valid}), 64'({{NR{1'b1}}, 4'b0000}));
        @(posedge Clk); #1;
        Reset = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rowval[0] = 16'h2211;
        rowval[1] = 16'h4433;
        repeat (3) @(posedge Clk);
        #1;
        check("reset_state", 64'({NRE, ADC, Busy, Done, Pix_valid, Pix_data, Pix_row, Pix_col}),
              64'({{NR{1'b1}}, 4'b0000, {DW{1'b0}}, {RW{1'b0}}, {CW{1'b0}}}));
        Reset = 0;
        @(posedge Clk); #1;
        run_frame(0, 0);
        run_frame(1, 0);
        run_frame(0, 1);
        run_frame(0, 0);
        abort_frame();
        run_frame(0, 0);
        junk_ones = 1;
        run_frame(0, 0);
        junk_ones = 0;
        for (int i = 0; i < 12; i++) begin
            for (int r = 0; r < NR; r++) rowval[r] = AW'($urandom);
            run_frame(2, i[0]);
            repeat ($urandom_range(0, 2)) @(posedge Clk);
            #1;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
